// File: rtl/pipe_elastic_chain_pkg.sv
// Shared definitions for the elastic pipeline chain: CPU stage indices and default sizing.
package pipe_elastic_chain_pkg;

    typedef enum logic [1:0] {
        PIPE_IF_ID  = 2'd0,
        PIPE_ID_EX  = 2'd1,
        PIPE_EX_MEM = 2'd2,
        PIPE_MEM_WB = 2'd3
    } pipe_stage_e;

    localparam int PIPE_CPU_STAGES    = 4;
    localparam int PIPE_DEFAULT_WIDTH = 64;
    localparam int PIPE_DEFAULT_CNT_W = 32;

endpackage

// File: rtl/pipe_elastic_stage.sv
// One elastic pipeline slot: valid bit plus payload, with load, drain and flush.
module pipe_elastic_stage #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             drain,
    input  logic             flush,
    input  logic [WIDTH-1:0] load_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d, data_q;

    // Flush beats load beats drain; a drained slot keeps stale data but is marked empty.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush) begin
            valid_d = 1'b0;
            data_d  = '0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/pipe_elastic_chain.sv
// N-stage elastic pipeline chain with per-stage hold/flush and forwarding taps.
// Optional perf counters are enabled by defining PIPE_PERF_CNT_EN.
module pipe_elastic_chain
    import pipe_elastic_chain_pkg::*;
#(
    parameter int WIDTH  = PIPE_DEFAULT_WIDTH,
    parameter int STAGES = PIPE_CPU_STAGES,
    parameter int CNT_W  = PIPE_DEFAULT_CNT_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    input  logic [STAGES-1:0]            stage_hold,
    input  logic [STAGES-1:0]            flush_mask,
    output logic [STAGES-1:0]            stage_valid,
    output logic [STAGES*WIDTH-1:0]      stage_data,
    output logic [$clog2(STAGES+1)-1:0]  occupancy,
    output logic [CNT_W-1:0]             stall_cnt,
    output logic [CNT_W-1:0]             bubble_cnt
);

    localparam int OCC_W = $clog2(STAGES+1);

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] move;
    logic [STAGES-1:0] load;
    logic              acc_head;
    logic [WIDTH-1:0]  sdata [STAGES];

    // Ready ripples from the consumer back to the producer; in_valid never enters it.
    always_comb begin : accept_chain
        logic [STAGES:0]   a;
        logic [STAGES-1:0] m;
        a         = '0;
        m         = '0;
        a[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            m[k] = v[k] & ~stage_hold[k] & a[k+1];
            a[k] = ~v[k] | m[k];
        end
        acc_head = a[0];
        move     = m;
    end

    always_comb begin
        load    = '0;
        load[0] = in_valid & acc_head;
        for (int k = 1; k < STAGES; k++) begin
            load[k] = move[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] src;
        if (k == 0) begin : g_head
            assign src = in_data;
        end else begin : g_link
            assign src = sdata[k-1];
        end

        pipe_elastic_stage #(.WIDTH(WIDTH)) u_stage (
            .clk       (clk),
            .reset     (reset),
            .load      (load[k]),
            .drain     (move[k]),
            .flush     (flush_mask[k]),
            .load_data (src),
            .valid     (v[k]),
            .data      (sdata[k])
        );

        assign stage_data[k*WIDTH +: WIDTH] = sdata[k];
    end

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < STAGES; k++) begin
            occupancy = occupancy + OCC_W'(v[k]);
        end
    end

    assign in_ready    = acc_head;
    assign stage_valid = v;
    assign out_valid   = v[STAGES-1] & ~stage_hold[STAGES-1];
    assign out_data    = sdata[STAGES-1];

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;

    // Producer blocked, and consumer willing but starved; both wrap naturally.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (in_valid & ~in_ready) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (out_ready & ~out_valid) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_elastic_chain.sv
// Scoreboard bench for pipe_elastic_chain: directed scenarios plus randomized hold/backpressure.
module tb_pipe_elastic_chain;

    localparam int W  = 8;
    localparam int S  = 4;
    localparam int CW = 32;
    localparam int OW = $clog2(S+1);
`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [W-1:0]    in_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [W-1:0]    out_data;
    logic [S-1:0]    stage_hold = '0;
    logic [S-1:0]    flush_mask = '0;
    logic [S-1:0]    stage_valid;
    logic [S*W-1:0]  stage_data;
    logic [OW-1:0]   occupancy;
    logic [CW-1:0]   stall_cnt;
    logic [CW-1:0]   bubble_cnt;

    int           total = 0;
    int           bad = 0;
    logic [W-1:0] exp_q [$];
    longint       stall_m = 0;
    longint       bubble_m = 0;

    pipe_elastic_chain #(.WIDTH(W), .STAGES(S), .CNT_W(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .stage_hold  (stage_hold),
        .flush_mask  (flush_mask),
        .stage_valid (stage_valid),
        .stage_data  (stage_data),
        .occupancy   (occupancy),
        .stall_cnt   (stall_cnt),
        .bubble_cnt  (bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every cycle, mid-period, compare what the DUT shows against the queue model.
    always @(negedge clk) begin
        if (!reset) begin
            check("occupancy", occupancy, exp_q.size());
            if (stage_hold == '0)
                check("in_ready_rule", in_ready, (exp_q.size() < S) || out_ready);
            if (stage_hold[S-1])
                check("held_out_valid", out_valid, 0);
            if (in_valid && !in_ready) stall_m++;
            if (out_ready && !out_valid) bubble_m++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out_extra actual=%0h required=none", out_data);
                end else begin
                    check("out_data", out_data, exp_q.pop_front());
                end
            end
            if (in_valid && in_ready && !flush_mask[0])
                exp_q.push_back(in_data);
        end
    end

    task automatic drain();
        in_valid   = 1'b0;
        stage_hold = '0;
        flush_mask = '0;
        out_ready  = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (exp_q.size() == 0 && occupancy == 0) break;
            cycle();
        end
        check("drain_left", exp_q.size(), 0);
        check("drain_occ", occupancy, 0);
    endtask

    task automatic latency_probe(input logic [W-1:0] d, output int n);
        in_valid = 1'b1;
        in_data  = d;
        n = -1;
        for (int k = 1; k <= 12; k++) begin
            cycle();
            if (k == 1) in_valid = 1'b0;
            if (out_valid) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        int first_out;
        int idx;
        int low_cnt;
        bit seen;
        bit acc;
        longint s0;
        longint b0;

        // Reset state
        cycle();
        cycle();
        check("rst_out_valid", out_valid, 0);
        check("rst_stage_valid", stage_valid, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_stage_data", stage_data, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_bubble_cnt", bubble_cnt, 0);
        reset = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);

        // Free-running stream 0x01..0x08
        out_ready = 1'b1;
        first_out = -1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = W'(i);
            #1;
            check("stream_in_ready", in_ready, 1);
            cycle();
            if (first_out < 0 && out_valid) first_out = i;
        end
        in_valid = 1'b0;
        check("stream_latency", first_out, S);
        check("stream_occ_full", occupancy, S);
        drain();

        // Fill under backpressure, then stall the producer, then drain
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data  = W'(i);
            #1;
            check("fill_in_ready", in_ready, 1);
            cycle();
        end
        in_data = 8'h05;
        check("full_in_ready", in_ready, 0);
        check("full_occ", occupancy, S);
        s0 = longint'(stall_cnt);
        repeat (3) cycle();
        check("stall_delta", longint'(stall_cnt) - s0, PERF ? 3 : 0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_out_valid", out_valid, 1);
            cycle();
        end
        check("drained_occ", occupancy, 0);
        b0 = longint'(bubble_cnt);
        repeat (2) cycle();
        check("bubble_delta", longint'(bubble_cnt) - b0, PERF ? 2 : 0);

        // One-cycle hold on stage 1 while streaming
        idx = 0;
        low_cnt = 0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            in_valid   = (idx < 8);
            in_data    = W'(8'h10 + idx);
            stage_hold = (cyc == 6) ? 4'b0010 : 4'b0000;
            #1;
            if (cyc == 6) check("hold_in_ready", in_ready, 0);
            if (out_valid) seen = 1'b1;
            else if (seen && exp_q.size() > 0) low_cnt++;
            acc = in_valid && in_ready;
            cycle();
            if (acc) idx++;
        end
        stage_hold = '0;
        check("hold_bubbles", low_cnt, 1);
        drain();

        // Flush the two youngest entries of a full, stalled chain
        out_ready = 1'b0;
        for (int i = 5; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = W'(i);
            cycle();
        end
        in_valid = 1'b0;
        check("pre_flush_valid", stage_valid, 4'b1111);
        flush_mask = 4'b0011;
        cycle();
        flush_mask = '0;
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        check("post_flush_occ", occupancy, 2);
        check("post_flush_valid", stage_valid, 4'b1100);
        check("post_flush_data", stage_data[2*W-1:0], 0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h09;
        cycle();
        drain();

        // Wrong-path kill: item accepted under flush_mask[0] disappears
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid   = 1'b1;
            in_data    = W'(8'h20 + i);
            flush_mask = (i == 3) ? 4'b0001 : 4'b0000;
            #1;
            if (i == 3) check("flush_in_ready", in_ready, 1);
            cycle();
        end
        flush_mask = '0;
        drain();

        // Asynchronous reset mid-stream
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = W'(8'h30 + i);
            cycle();
        end
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        exp_q.delete();
        stall_m  = 0;
        bubble_m = 0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_stage_valid", stage_valid, 0);
        check("arst_occupancy", occupancy, 0);
        check("arst_stage_data", stage_data, 0);
        check("arst_stall_cnt", stall_cnt, 0);
        cycle();
        #2;
        reset = 1'b0;
        #1;
        check("arst_in_ready", in_ready, 1);
        latency_probe(8'h40, first_out);
        check("arst_latency", first_out, S);
        drain();

        // Randomized holds and backpressure
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [S-1:0] h;
            h = '0;
            for (int k = 0; k < S; k++) h[k] = ($urandom_range(0, 4) == 0);
            in_valid   = ($urandom_range(0, 3) != 0);
            in_data    = W'($urandom);
            out_ready  = ($urandom_range(0, 3) != 0);
            stage_hold = h;
            cycle();
        end
        drain();

        check("final_stall_cnt", longint'(stall_cnt), PERF ? stall_m : 0);
        check("final_bubble_cnt", longint'(bubble_cnt), PERF ? bubble_m : 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
